// File: rtl/digit_feeder_163_8.sv
// Operand front-end for the 163-bit, 8-bit-digit systolic GF(2^163) multiplier.
// Optional build macro FEEDER_OVERLAP_EN: accept a new operand pair while the array drains.
module digit_feeder_163_8 #(
    parameter int M       = 163,
    parameter int D       = 8,
    parameter int NDIG    = 21,
    parameter int ARR_LAT = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         op_valid,
    output logic         op_ready,
    input  logic [M-1:0] a_in,
    input  logic [M-1:0] b_in,
    output logic [M-1:0] a_out,
    output logic [M-1:0] g_out,
    output logic [D-1:0] b_digit,
    output logic         digit_valid,
    output logic         first_digit,
    output logic         last_digit,
    output logic         busy,
    output logic         done
);

    localparam int BW = NDIG * D;
    localparam int CW = $clog2(NDIG);
    localparam logic [CW-1:0] LAST_CNT = CW'(NDIG - 1);

    typedef enum logic [1:0] {IDLE, FEED, DRAIN} state_t;

    state_t              state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [M-1:0]        a_q, a_d;
    logic [BW-1:0]       b_sh_q, b_sh_d;
    logic [ARR_LAT-1:0]  dl_q, dl_d;
    logic                accept;

    assign accept = op_valid & op_ready;
    assign g_out  = M'('hC9);
    assign a_out  = a_q;
    assign done   = dl_q[ARR_LAT-1];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = FEED;
            FEED:    if (cnt_q == LAST_CNT) state_d = DRAIN;
            DRAIN: begin
                // A DRAIN accept is only possible in the overlap build.
                if (accept)    state_d = FEED;
                else if (done) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy        = (state_q != IDLE);
        digit_valid = (state_q == FEED);
        first_digit = digit_valid && (cnt_q == '0);
        last_digit  = digit_valid && (cnt_q == LAST_CNT);
        b_digit     = digit_valid ? b_sh_q[BW-1 -: D] : '0;
`ifdef FEEDER_OVERLAP_EN
        op_ready    = (state_q == IDLE) || (state_q == DRAIN);
`else
        op_ready    = (state_q == IDLE);
`endif
    end

    always_comb begin
        cnt_d  = cnt_q;
        a_d    = a_q;
        b_sh_d = b_sh_q;
        if (accept) begin
            a_d    = a_in;
            b_sh_d = {{(BW-M){1'b0}}, b_in};
            cnt_d  = '0;
        end else if (state_q == FEED) begin
            b_sh_d = b_sh_q << D;
            cnt_d  = (cnt_q == LAST_CNT) ? '0 : cnt_q + 1'b1;
        end
        // done delay line keeps shifting in every state so an in-flight pulse is never lost.
        dl_d[0] = last_digit;
        for (int i = 1; i < ARR_LAT; i++) begin
            dl_d[i] = dl_q[i-1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
            a_q   <= '0;
            dl_q  <= '0;
        end else begin
            cnt_q <= cnt_d;
            a_q   <= a_d;
            dl_q  <= dl_d;
        end
    end

    // Shift data needs no reset: b_digit is gated by the FEED state.
    always_ff @(posedge clk) begin
        b_sh_q <= b_sh_d;
    end

endmodule

// File: tb/tb_digit_feeder_163_8.sv
// Self-checking bench for digit_feeder_163_8: vector table plus digit/done scoreboard.
module tb_digit_feeder_163_8;

    localparam int M       = 163;
    localparam int D       = 8;
    localparam int NDIG    = 21;
    localparam int ARR_LAT = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         op_valid;
    logic         op_ready;
    logic [M-1:0] a_in, b_in, a_out, g_out;
    logic [D-1:0] b_digit;
    logic         digit_valid, first_digit, last_digit, busy, done;

    digit_feeder_163_8 #(.M(M), .D(D), .NDIG(NDIG), .ARR_LAT(ARR_LAT)) dut (
        .clk(clk), .rst(rst), .op_valid(op_valid), .op_ready(op_ready),
        .a_in(a_in), .b_in(b_in), .a_out(a_out), .g_out(g_out),
        .b_digit(b_digit), .digit_valid(digit_valid), .first_digit(first_digit),
        .last_digit(last_digit), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [7:0] dig;
        bit         first;
        bit         last;
        int         cyc;
    } exp_t;

    typedef struct {
        logic [M-1:0] a;
        logic [M-1:0] b;
        logic [7:0]   d0;
        logic [7:0]   d20;
    } vec_t;

    exp_t sq[$];
    int   dq[$];
    int   done_hist[$];
    int   checks = 0;
    int   errors = 0;
    int   done_cnt = 0;
    logic [7:0] obs_d0, obs_d20;

    function automatic void chk(input string name, input logic [M-1:0] act, input logic [M-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst) begin
                sq.delete();
                dq.delete();
            end else begin
                if (digit_valid) begin
                    if (sq.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL unexpected_digit: got %0h expected none (cycle %0d)", b_digit, cyc);
                    end else begin
                        e = sq.pop_front();
                        chk("digit", M'({b_digit, first_digit, last_digit}), M'({e.dig, e.first, e.last}));
                        chk("digit_cycle", M'(cyc), M'(e.cyc));
                        if (first_digit) obs_d0 = b_digit;
                        if (last_digit) obs_d20 = b_digit;
                    end
                end else begin
                    chk("digit_zero_when_invalid", M'({b_digit, first_digit, last_digit}), '0);
                end
                if (done) begin
                    done_cnt++;
                    done_hist.push_back(cyc);
                    if (dq.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL unexpected_done: got 1 expected 0 (cycle %0d)", cyc);
                    end else begin
                        chk("done_cycle", M'(cyc), M'(dq.pop_front()));
                    end
                end else if (dq.size() != 0 && cyc > dq[0]) begin
                    checks++; errors++;
                    $display("FAIL missing_done: got none expected at cycle %0d", dq.pop_front());
                end
`ifdef FEEDER_OVERLAP_EN
                chk("op_ready", M'(op_ready), M'(!digit_valid));
`else
                chk("op_ready", M'(op_ready), M'(!busy));
`endif
            end
        end
    endtask

    task automatic send(input logic [M-1:0] a, input logic [M-1:0] b, input bit hold, output int k);
        int w;
        logic [8*NDIG-1:0] bp;
        exp_t e;
        w = 0;
        @(negedge clk);
        op_valid = 1'b1;
        a_in = a;
        b_in = b;
        while (!op_ready && w < 100) begin
            @(negedge clk);
            w++;
        end
        if (!op_ready) begin
            checks++; errors++;
            $display("FAIL accept_timeout: got op_ready 0 expected 1 within 100 cycles");
            op_valid = 1'b0;
            k = -1;
            return;
        end
        k = cyc + 1;
        bp = {5'b0, b};
        for (int i = 0; i < NDIG; i++) begin
            e.dig   = bp[8*NDIG-1-8*i -: 8];
            e.first = (i == 0);
            e.last  = (i == NDIG - 1);
            e.cyc   = k + i;
            sq.push_back(e);
        end
        dq.push_back(k + NDIG - 1 + ARR_LAT);
        @(posedge clk);
        #1;
        if (!hold) op_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int w;
        w = 0;
        while ((sq.size() != 0 || dq.size() != 0) && w < 200) begin
            @(negedge clk);
            w++;
        end
        if (sq.size() != 0 || dq.size() != 0) begin
            checks++; errors++;
            $display("FAIL drain_timeout: got %0d pending expected 0", sq.size() + dq.size());
            sq.delete();
            dq.delete();
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_op_ready"}, M'(op_ready), M'(1));
        chk({tag, "_a_out"}, a_out, '0);
        chk({tag, "_outs"}, M'({b_digit, digit_valid, first_digit, last_digit, busy, done}), '0);
    endtask

    vec_t vecs[4];
    int   k1, k2, dc_before;

    initial begin
        vecs[0] = '{a: M'(1), b: M'(1), d0: 8'h00, d20: 8'h01};
        vecs[1] = '{a: '0, b: {M{1'b1}}, d0: 8'h07, d20: 8'hFF};
        vecs[2] = '{a: {M{1'b1}}, b: M'(5) << 160, d0: 8'h05, d20: 8'h00};
        vecs[3] = '{a: M'(163'h1234_5678_9ABC), b: (M'(4) << 160) | M'(8'h3C), d0: 8'h04, d20: 8'h3C};

        rst = 1'b1;
        op_valid = 1'b0;
        a_in = '0;
        b_in = '0;
        fork
            monitor();
        join_none
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_reset_values("reset");
        chk("g_out", g_out, M'(8'hC9));

        for (int v = 0; v < 4; v++) begin
            send(vecs[v].a, vecs[v].b, 1'b0, k1);
            wait_idle();
            chk("vec_a_out", a_out, vecs[v].a);
            chk("vec_digit0", M'(obs_d0), M'(vecs[v].d0));
            chk("vec_digit20", M'(obs_d20), M'(vecs[v].d20));
        end

        // Reset for three cycles in the middle of FEED aborts the operation.
        send(M'(7), {M{1'b1}}, 1'b0, k1);
        repeat (5) @(posedge clk);
        #1 rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_reset_values("midfeed_reset");
        dc_before = done_cnt;
        repeat (40) @(negedge clk);
        chk("no_done_after_abort", M'(done_cnt - dc_before), '0);

        // Same-cycle reset and operand: reset wins.
        @(posedge clk);
        #1;
        rst = 1'b1;
        op_valid = 1'b1;
        a_in = M'(163'hABCDEF);
        b_in = M'(163'h55);
        @(posedge clk);
        #1;
        rst = 1'b0;
        op_valid = 1'b0;
        @(negedge clk);
        check_reset_values("rst_and_valid");
        repeat (5) @(negedge clk);

        // Held op_valid during FEED with new operands, then back-to-back second op.
        dc_before = done_cnt;
        done_hist.delete();
        send(M'(163'h1111), M'(163'h0F0F_0F0F), 1'b1, k1);
        a_in = M'(163'h2222);
        b_in = M'(163'h7777_8888);
        for (int i = 0; i < NDIG; i++) begin
            @(negedge clk);
            chk("stall_a_hold", a_out, M'(163'h1111));
        end
        send(M'(163'h2222), M'(163'h7777_8888), 1'b0, k2);
        wait_idle();
        chk("second_a_out", a_out, M'(163'h2222));
        chk("two_done_pulses", M'(done_cnt - dc_before), M'(2));
`ifdef FEEDER_OVERLAP_EN
        chk("overlap_accept_gap", M'(k2 - k1), M'(NDIG + 1));
        if (done_hist.size() == 2)
            chk("overlap_done_gap", M'(done_hist[1] - done_hist[0]), M'(NDIG + 1));
`else
        chk("accept_after_done", M'(k2 > k1 + NDIG - 1 + ARR_LAT), M'(1));
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
